// File: rtl/dcp_pkg.sv
// Shared definitions for the debug control processor (DCP) register-dump path.
// Contents:
//   TX_WORD / TX_CHAR   item type codes understood by the UART TX arbiter
//   CHAR_CR / CHAR_LF   line terminator characters sent after a dump
//   dump_state_t        state encoding of the dcp_reg_dump sequencer
package dcp_pkg;

    localparam logic [1:0] TX_CHAR = 2'b00;
    localparam logic [1:0] TX_WORD = 2'b01;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SNAP,
        ST_SEND,
        ST_WAIT,
        ST_CR,
        ST_WAIT_CR,
        ST_LF,
        ST_WAIT_LF,
        ST_DONE
    } dump_state_t;

endpackage

// File: rtl/dcp_reg_dump.sv
// Register-dump engine: on start, freezes NUM_REGS registers and streams them
// in index order to the UART TX arbiter (req/ack), then sends CR/LF and pulses
// finish. abort cancels a running dump (finish still pulses, no terminator).
//
// Build option: DCP_DUMP_MASK_EN adds the reg_mask port; registers whose mask
// bit is 0 are skipped without a bus cycle. Without it every register is sent.
//
// Ports:
//   clk       system clock, rising edge
//   rstn      asynchronous active-low reset
//   start     1-cycle dump command (ignored while a dump runs)
//   abort     1-cycle cancel of a running dump
//   regs      flat register bus, reg i = regs[i*DATA_W +: DATA_W]
//   reg_mask  (DCP_DUMP_MASK_EN only) 1 = include reg i
//   req_tx    transfer request, held until ack_tx
//   type_tx   TX_WORD or TX_CHAR
//   dout      word payload or zero-extended character
//   ack_tx    arbiter accepted the current item
//   busy      dump in progress
//   finish    1-cycle pulse at dump completion or abort
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for start
// ST_SNAP    | mask latched, first enabled register located
// ST_SEND    | load word item for snap[idx]
// ST_WAIT    | word request outstanding, waiting for ack
// ST_CR      | load CR character item
// ST_WAIT_CR | CR request outstanding
// ST_LF      | load LF character item
// ST_WAIT_LF | LF request outstanding
// ST_DONE    | finish pulse, back to idle
module dcp_reg_dump
    import dcp_pkg::*;
#(
    parameter int NUM_REGS = 9,
    parameter int DATA_W   = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_REGS*DATA_W-1:0] regs,
`ifdef DCP_DUMP_MASK_EN
    input  logic [NUM_REGS-1:0]        reg_mask,
`endif
    output logic                       req_tx,
    output logic [1:0]                 type_tx,
    output logic [DATA_W-1:0]          dout,
    input  logic                       ack_tx,
    output logic                       busy,
    output logic                       finish
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    dump_state_t          state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [DATA_W-1:0]    snap [NUM_REGS];
    logic [NUM_REGS-1:0]  en_mask;
    logic [NUM_REGS-1:0]  live_mask;
    logic [IDX_W:0]       hit;
    logic                 req_nxt, busy_nxt, finish_nxt;
    logic [1:0]           type_nxt;
    logic [DATA_W-1:0]    dout_nxt;

`ifdef DCP_DUMP_MASK_EN
    assign live_mask = reg_mask;
`else
    assign live_mask = '1;
`endif

    // Lowest set bit of m at or above position from; MSB of result = found.
    function automatic logic [IDX_W:0] find_en(input logic [NUM_REGS-1:0] m, input int from);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (i >= from && m[i]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            idx     <= '0;
            en_mask <= '0;
            req_tx  <= 1'b0;
            type_tx <= 2'b00;
            dout    <= '0;
            busy    <= 1'b0;
            finish  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            req_tx  <= req_nxt;
            type_tx <= type_nxt;
            dout    <= dout_nxt;
            busy    <= busy_nxt;
            finish  <= finish_nxt;
            if (state == ST_SNAP) en_mask <= live_mask;
        end
    end

    // The register image is frozen on the very edge that accepts start, so any
    // change to regs from the SNAP cycle onwards cannot reach the output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) snap[i] <= '0;
        end else if (state == ST_IDLE && start) begin
            for (int i = 0; i < NUM_REGS; i++) snap[i] <= regs[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        req_nxt   = 1'b0;
        type_nxt  = type_tx;
        dout_nxt  = dout;
        hit       = '0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_SNAP;
            ST_SNAP: begin
                hit       = find_en(live_mask, 0);
                idx_nxt   = hit[IDX_W-1:0];
                state_nxt = hit[IDX_W] ? ST_SEND : ST_CR;
            end
            ST_SEND: begin
                req_nxt   = 1'b1;
                type_nxt  = TX_WORD;
                dout_nxt  = snap[idx];
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                req_nxt = 1'b1;
                if (ack_tx) begin
                    req_nxt   = 1'b0;
                    hit       = find_en(en_mask, int'(idx) + 1);
                    idx_nxt   = hit[IDX_W] ? hit[IDX_W-1:0] : idx;
                    state_nxt = hit[IDX_W] ? ST_SEND : ST_CR;
                end
            end
            ST_CR: begin
                req_nxt   = 1'b1;
                type_nxt  = TX_CHAR;
                dout_nxt  = DATA_W'(CHAR_CR);
                state_nxt = ST_WAIT_CR;
            end
            ST_WAIT_CR: begin
                req_nxt = !ack_tx;
                if (ack_tx) state_nxt = ST_LF;
            end
            ST_LF: begin
                req_nxt   = 1'b1;
                type_nxt  = TX_CHAR;
                dout_nxt  = DATA_W'(CHAR_LF);
                state_nxt = ST_WAIT_LF;
            end
            ST_WAIT_LF: begin
                req_nxt = !ack_tx;
                if (ack_tx) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Abort overrides everything, including an ack arriving in the same cycle.
        if (abort && state != ST_IDLE && state != ST_DONE) begin
            state_nxt = ST_DONE;
            req_nxt   = 1'b0;
        end
        busy_nxt   = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
        finish_nxt = (state_nxt == ST_DONE);
    end

endmodule
